r2r_sar_adc: RTL

Successive-approximation controller for the R2R-ladder ADC front end. It drives an 8-bit code onto the R2R resistor DAC and waits for the ladder to settle. It then samples the external comparator (Vin vs Vdac) and binary-searches one bit per trial. Each finished conversion is presented as a held 8-bit word with a one-cycle valid pulse. This block feeds the `data` input of the downstream R2R averaging/scaling stage.

---
 rtl/r2r_pkg.sv | 16 +
 rtl/r2r_comp_sync.sv | 26 ++
 rtl/r2r_sar_adc.sv | 116 +++++++++++
 3 files changed

// File: rtl/r2r_pkg.sv
// Shared types and constants for the R2R ladder ADC path.
// R2R_BITS is also the downstream r2r_processing INPUT_BITS.
package r2r_pkg;

    localparam int R2R_BITS           = 8;
    localparam int R2R_SETTLE_DEFAULT = 250;

    typedef enum logic [2:0] {
        IDLE,
        TRIAL,
        SETTLE,
        DECIDE,
        DONE
    } sar_state_t;

endpackage

// File: rtl/r2r_comp_sync.sv
// N-stage flip-flop synchronizer for the asynchronous comparator output.
module r2r_comp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_ff;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ff <= '0;
        end else begin
            r_ff[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_ff[i] <= r_ff[i-1];
            end
        end
    end

    assign o_sync = r_ff[STAGES-1];

endmodule

// File: rtl/r2r_sar_adc.sv
// SAR controller for the R2R ladder ADC: one bit per trial, the ladder is held
// SETTLE_CYCLES before each comparator decision, results are pulsed on data_valid.
module r2r_sar_adc
    import r2r_pkg::*;
#(
    parameter int DAC_BITS      = R2R_BITS,
    parameter int SETTLE_CYCLES = R2R_SETTLE_DEFAULT,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                comp_in,
    output logic [DAC_BITS-1:0] dac_out,
    output logic [DAC_BITS-1:0] data,
    output logic                data_valid,
    output logic                busy
);

    localparam int IDX_W = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(DAC_BITS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_bad_settle
            $error("r2r_sar_adc: SETTLE_CYCLES must be >= SYNC_STAGES+1");
        end
    endgenerate

    sar_state_t          r_state;
    sar_state_t          w_next;
    logic [DAC_BITS-1:0] r_dac;
    logic [DAC_BITS-1:0] r_result;
    logic [DAC_BITS-1:0] r_data;
    logic                r_valid;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_comp_s;
    logic [DAC_BITS-1:0] w_mask;
    logic [DAC_BITS-1:0] w_decided;

    r2r_comp_sync #(
        .STAGES (SYNC_STAGES)
    ) u_comp_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (comp_in),
        .o_sync  (w_comp_s)
    );

    assign w_mask    = DAC_BITS'(1) << r_bit_idx;
    assign w_decided = w_comp_s ? r_dac : (r_dac & ~w_mask);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (enable) w_next = TRIAL;
            TRIAL:   w_next = SETTLE;
            SETTLE:  if (r_cnt == '0) w_next = DECIDE;
            DECIDE:  w_next = (r_bit_idx == '0) ? DONE : TRIAL;
            DONE:    w_next = enable ? TRIAL : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath follows the registered state; bit_idx stops at 0 and never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dac     <= '0;
            r_result  <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_bit_idx <= '0;
            r_cnt     <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (enable) begin
                        r_bit_idx <= MSB_IDX;
                        r_result  <= '0;
                    end
                end
                TRIAL: begin
                    r_dac <= r_result | w_mask;
                    r_cnt <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                DECIDE: begin
                    r_result <= w_decided;
                    if (r_bit_idx == '0) begin
                        r_data  <= w_decided;
                        r_valid <= 1'b1;
                    end else begin
                        r_bit_idx <= r_bit_idx - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dac_out    = r_dac;
    assign data       = r_data;
    assign data_valid = r_valid;
    assign busy       = (r_state != IDLE);

endmodule
